// File: rtl/fft_mux_arbiter.sv
// Round-robin arbiter and burst sequencer for the 4-to-1 operand mux
// feeding the shared FFT butterfly. One requester is granted at a time,
// beats are handshaked with out_valid/out_ready, and sel is held while idle
// so the mux inputs stay quiet.
module fft_mux_arbiter #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic       busy,
    output logic [7:0] beat_cnt
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N_REQ-1:0]   grant_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               busy_n;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   cand;
    logic               found;
    logic               accept;
    logic               cap_hit;

    // Beat handshake; only the granted requester is observed.
    assign out_valid = busy & req[sel];
    assign accept    = out_valid & out_ready;
    assign cap_hit   = ({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BEATS);

    // Round-robin search starting just after the last winner.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = SEL_W'(ptr + SEL_W'(k));
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        grant_n = grant;
        cnt_n   = beat_cnt;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    sel_n   = winner;
                    ptr_n   = winner;
                    grant_n = N_REQ'(1) << winner;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                // Abort, final beat, or fairness cap all release the path;
                // a last beat that also hits the cap releases only once.
                if (!req[sel] || (accept && (last[sel] || cap_hit))) begin
                    state_n = IDLE;
                    grant_n = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (accept) begin
                    cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= SEL_W'(3);
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            grant    <= grant_n;
            beat_cnt <= cnt_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_fft_mux_arbiter.sv
// Directed bench for fft_mux_arbiter: one task per scenario, inline checks.
// A second instance with MAX_BEATS=4 covers the fairness cap.
module tb_fft_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;

    logic [1:0] sel,  sel4;
    logic [3:0] grant, grant4;
    logic       out_valid, out_valid4;
    logic       busy, busy4;
    logic [7:0] beat_cnt, beat_cnt4;

    int errors = 0;
    int checks = 0;
    logic [15:0] got;
    logic [15:0] want;

    fft_mux_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
        .sel(sel), .grant(grant), .out_valid(out_valid), .busy(busy),
        .beat_cnt(beat_cnt)
    );

    fft_mux_arbiter #(.MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
        .sel(sel4), .grant(grant4), .out_valid(out_valid4), .busy(busy4),
        .beat_cnt(beat_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot fields: busy, grant, sel, beat_cnt, out_valid.
    function automatic logic [15:0] snap();
        return {busy, grant, sel, beat_cnt, out_valid};
    endfunction

    function automatic logic [15:0] snap4();
        return {busy4, grant4, sel4, beat_cnt4, out_valid4};
    endfunction

    function automatic logic [15:0] mk(input logic b, input logic [3:0] g,
                                       input logic [1:0] s, input logic [7:0] c,
                                       input logic v);
        return {b, g, s, c, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; last = 4'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0; last = 4'b0; out_ready = 1'b0;
        step();
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL reset: got %b want %b", got, want); end
        checks++; got = snap4(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL reset_cap4: got %b want %b", got, want); end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL single_grant: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b1);
        if (got !== want) begin errors++; $display("FAIL single_beat1: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd2, 1'b1);
        if (got !== want) begin errors++; $display("FAIL single_beat2: got %b want %b", got, want); end
        last = 4'b0001;
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL single_release: got %b want %b", got, want); end
        req = 4'b0000; last = 4'b0000;
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL single_idle_hold: got %b want %b", got, want); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] s;
            s = 2'(i % 4);
            step();
            checks++; got = snap(); want = mk(1'b1, 4'(1 << s), s, 8'd0, 1'b1);
            if (got !== want) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, got, want); end
            step();
            checks++; got = snap(); want = mk(1'b0, 4'b0000, s, 8'd0, 1'b0);
            if (got !== want) begin errors++; $display("FAIL rr_bubble%0d: got %b want %b", i, got, want); end
        end
        req = 4'b0000; last = 4'b0000;
    endtask

    task automatic test_max_beats();
        logic [3:0] rq [4];
        logic [1:0] nx [4];
        logic [1:0] cur;
        rq[0] = 4'b0100; nx[0] = 2'd2;
        rq[1] = 4'b0110; nx[1] = 2'd1;
        rq[2] = 4'b0110; nx[2] = 2'd2;
        rq[3] = 4'b1100; nx[3] = 2'd3;
        do_reset();
        req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
        step();
        checks++; got = snap4(); want = mk(1'b1, 4'b0100, 2'd2, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL cap_first_grant: got %b want %b", got, want); end
        cur = 2'd2;
        for (int p = 0; p < 4; p++) begin
            req = rq[p];
            for (int i = 1; i <= 3; i++) begin
                step();
                checks++; got = snap4(); want = mk(1'b1, 4'(1 << cur), cur, 8'(i), 1'b1);
                if (got !== want) begin errors++; $display("FAIL cap_p%0d_beat%0d: got %b want %b", p, i, got, want); end
            end
            step();
            checks++; got = snap4(); want = mk(1'b0, 4'b0000, cur, 8'd0, 1'b0);
            if (got !== want) begin errors++; $display("FAIL cap_p%0d_release: got %b want %b", p, got, want); end
            step();
            checks++; got = snap4(); want = mk(1'b1, 4'(1 << nx[p]), nx[p], 8'd0, 1'b1);
            if (got !== want) begin errors++; $display("FAIL cap_p%0d_next: got %b want %b", p, got, want); end
            cur = nx[p];
        end
        req = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL stall_grant: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b1);
        if (got !== want) begin errors++; $display("FAIL stall_accept1: got %b want %b", got, want); end
        out_ready = 1'b0;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b1);
        if (got !== want) begin errors++; $display("FAIL stall_hold2: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b1);
        if (got !== want) begin errors++; $display("FAIL stall_hold3: got %b want %b", got, want); end
        out_ready = 1'b1; last = 4'b0001;
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL stall_release: got %b want %b", got, want); end
        req = 4'b0000; last = 4'b0000;
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0011; last = 4'b0000; out_ready = 1'b1;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL abort_grant: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b1);
        if (got !== want) begin errors++; $display("FAIL abort_beat1: got %b want %b", got, want); end
        req = 4'b0010;
        #1;
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd1, 1'b0);
        if (got !== want) begin errors++; $display("FAIL abort_valid_drop: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL abort_release: got %b want %b", got, want); end
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0010, 2'd1, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL abort_next: got %b want %b", got, want); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0010, 2'd1, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL rstmid_grant: got %b want %b", got, want); end
        repeat (5) step();
        checks++; got = snap(); want = mk(1'b1, 4'b0010, 2'd1, 8'd5, 1'b1);
        if (got !== want) begin errors++; $display("FAIL rstmid_cnt5: got %b want %b", got, want); end
        rst = 1'b1; req = 4'b1111;
        step();
        checks++; got = snap(); want = mk(1'b0, 4'b0000, 2'd0, 8'd0, 1'b0);
        if (got !== want) begin errors++; $display("FAIL rstmid_cleared: got %b want %b", got, want); end
        rst = 1'b0;
        step();
        checks++; got = snap(); want = mk(1'b1, 4'b0001, 2'd0, 8'd0, 1'b1);
        if (got !== want) begin errors++; $display("FAIL rstmid_regrant0: got %b want %b", got, want); end
        req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; last = 4'b0; out_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_beats();
        test_stall();
        test_abort();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the run in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft_mux_arbiter.md
# fft_mux_arbiter

Round-robin arbiter and sequencer for the 4-to-1 operand multiplexer that feeds the shared butterfly unit of the low-power DIT FFT. Four requesters (stage address generators / memory banks) request the butterfly path. The block grants one requester at a time for a burst of beats, drives the 2-bit mux select, and handshakes beats to the butterfly with valid/ready. It holds the select steady while idle so the mux inputs do not toggle downstream logic needlessly.

## Interface
- `MAX_BEATS`, default 16: maximum beats per grant before forced release (fairness bound); legal range 1..255.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `req` input, 4: `req[i]` is high while requester i has a beat to present.
- `last` input, 4: `last[i]` marks requester i's current beat as the final beat of its burst.
- `out_ready` input, 1: the butterfly accepts a beat this cycle.
- `sel` output, 2: mux control, index of the granted requester (0..3).
- `grant` output, 4: one-hot grant, all zero when idle.
- `out_valid` output, 1: the muxed beat is valid for the butterfly.
- `busy` output, 1: a grant is active.
- `beat_cnt` output, 8: beats accepted in the current grant.

## Operation
- The FSM has two states, IDLE and GRANT. Reset puts it in IDLE with `ptr`=3, `sel`=0, `grant`=0, `out_valid`=0, `busy`=0, and `beat_cnt`=0.
- IDLE:
  - If `req`≠0, pick the winner: the first i with `req[i]`=1, searching `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4).
  - Register `sel`=winner, `grant`=1<<winner, and `ptr`=winner, then go to GRANT.
  - If `req`=0, stay in IDLE and hold `sel` at its previous value (no toggle).
- GRANT:
  - `out_valid` = `req[sel]` (combinational from the registered `sel`).
  - A beat is accepted when `out_valid`&&`out_ready`; `beat_cnt` increments on each accept.
- Release from GRANT to IDLE happens on the first of these. Release clears `grant`, `busy` and `beat_cnt` at the next edge; `sel` is held.
  - (a) A beat is accepted with `last[sel]`=1.
  - (b) A beat is accepted and `beat_cnt`+1 == `MAX_BEATS`.
  - (c) `req[sel]`=0 (requester abort); no beat is accepted that cycle.
- Only the granted requester's `req` and `last` are observed in GRANT. Other requests wait.
- `beat_cnt` never exceeds `MAX_BEATS`; it is 8 bits and cannot wrap.

## Timing
- Arbitration latency: `req` rising before edge N gives `grant`/`sel`/`busy` valid after edge N. The first beat can be accepted in cycle N+1.
- Every grant ends with exactly one IDLE bubble cycle. Back-to-back bursts to different requesters are therefore spaced ≥1 idle cycle apart.
- Simultaneous requests are resolved purely by the `ptr` rotation. With all four requesting continuously, the grant order is 0,1,2,3,0,…
- `out_ready` low stalls: `beat_cnt`, `sel` and the state are held.
- `rst` asserted mid-GRANT returns every output to its reset value at the next edge. Any in-flight beat is dropped.
- `last` with `MAX_BEATS` reached on the same beat: a single release occurs, with no double count.

## Test plan
- Reset, then `req`=4'b0001 with `last[0]` set on the 3rd beat and `out_ready`=1 → `grant`=0001, `sel`=0 one cycle after the request. 3 accepts, `beat_cnt` 0→1→2, then `busy`=0 and `sel` stays 0.
- `req`=4'b1111 held, each burst 1 beat (`last`=4'b1111) → grants 0,1,2,3,0 with one IDLE cycle between grants.
- `MAX_BEATS`=4, `req[2]` held and `last[2]`=0 → exactly 4 accepts, then forced release. With `req[1]` also high, the next grant goes to 3 if requesting, otherwise 1. With only `req[2]`, it is re-granted to 2.
- `out_ready` toggling 1,0,0,1 during a 2-beat burst → `out_valid` stays high and accepts occur only in cycles 1 and 4. `beat_cnt` holds during the stall.
- `req[sel]` dropped mid-burst after 1 beat → release with no accept, `grant`=0 next cycle, and the other pending requester is granted the cycle after.
- `rst` pulsed during GRANT with `beat_cnt`=5 → next cycle all outputs are 0, `sel`=0, and a subsequent all-request grant goes to requester 0.
